// File: rtl/point_fill_arbiter.sv
// point_fill_arbiter
// Round-robin arbiter that grants one requester at a time the shared
// point-fill datapath. The granted requester's point (1..MAX_DIM coordinates)
// is assembled beat by beat from the shared coordinate stream, then presented
// as a completed point until the consumer accepts it.
// pt_owner is two bits wide, so NUM_REQ is expected to be at most 4.
module point_fill_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int COORD_W = 32,
  parameter int MAX_DIM = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*2-1:0]       req_dim,
  output logic [NUM_REQ-1:0]         gnt,
  input  logic                       coord_valid,
  input  logic [COORD_W-1:0]         coord_data,
  output logic                       coord_ready,
  output logic                       pt_valid,
  output logic [MAX_DIM*COORD_W-1:0] pt_data,
  output logic [1:0]                 pt_dim,
  output logic [1:0]                 pt_owner,
  input  logic                       pt_ready,
  output logic                       err_dim
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [1:0]                   ptr_q, ptr_d;
  logic [1:0]                   beat_q, beat_d;
  logic [1:0]                   dim_q, dim_d;
  logic [1:0]                   owner_q, owner_d;
  logic [MAX_DIM*COORD_W-1:0]   data_q, data_d;
  logic                         coord_ready_q, coord_ready_d;
  logic                         pt_valid_q, pt_valid_d;

  logic                         any_req;
  logic [1:0]                   win_idx;
  logic [1:0]                   win_dim;
  logic                         win_legal;

  // Round-robin search: first active request at or after ptr, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    any_req   = 1'b0;
    win_idx   = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        win_idx = 2'(idx);
      end
    end
    win_dim   = req_dim[2*win_idx +: 2];
    win_legal = (win_dim != 2'd0) && (int'(win_dim) <= MAX_DIM);
  end

  // Grant and dimension error must appear in the same cycle as the request is
  // seen in IDLE, so they are decoded combinationally and forced low in reset.
  always_comb begin
    gnt     = '0;
    err_dim = 1'b0;
    if (rst_n && (state_q == IDLE) && any_req) begin
      gnt[win_idx] = 1'b1;
      err_dim      = !win_legal;
    end
  end

  // Next-state logic: grant/latch in IDLE, collect beats in FILL, hold in OUT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    dim_d   = dim_q;
    owner_d = owner_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          ptr_d   = (int'(win_idx) == NUM_REQ - 1) ? 2'd0 : win_idx + 2'd1;
          owner_d = win_idx;
          dim_d   = win_dim;
          data_d  = '0;
          beat_d  = 2'd0;
          if (win_legal) begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (coord_valid && coord_ready_q) begin
          for (int k = 0; k < MAX_DIM; k++) begin
            if (int'(beat_q) == k) begin
              data_d[k*COORD_W +: COORD_W] = coord_data;
            end
          end
          if (beat_q + 2'd1 == dim_q) begin
            state_d = OUT;
            beat_d  = 2'd0;
          end else begin
            beat_d  = beat_q + 2'd1;
          end
        end
      end
      OUT: begin
        if (pt_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    coord_ready_d = (state_d == FILL);
    pt_valid_d    = (state_d == OUT);
  end

  // State, arbitration pointer, point buffer and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= 2'd0;
      beat_q        <= 2'd0;
      dim_q         <= 2'd0;
      owner_q       <= 2'd0;
      data_q        <= '0;
      coord_ready_q <= 1'b0;
      pt_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      beat_q        <= beat_d;
      dim_q         <= dim_d;
      owner_q       <= owner_d;
      data_q        <= data_d;
      coord_ready_q <= coord_ready_d;
      pt_valid_q    <= pt_valid_d;
    end
  end

  assign coord_ready = coord_ready_q;
  assign pt_valid    = pt_valid_q;
  assign pt_data     = data_q;
  assign pt_dim      = dim_q;
  assign pt_owner    = owner_q;

endmodule

// File: doc/point_fill_arbiter.md
POINT_FILL_ARBITER -- requirements
Module: point_fill_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of requesters sharing the point-fill datapath.
REQ-002 SHALL have parameter COORD_W, default 32, width of one coordinate.
REQ-003 SHALL have parameter MAX_DIM, default 3, maximum coordinates per point.
REQ-004 SHALL use one clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock.
REQ-005 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have req  input  NUM_REQ  per-requester fill request, level, held until granted.
REQ-007 SHALL have req_dim  input  NUM_REQ*2  requested dimension of requester i in bits [2i+1:2i].
REQ-008 SHALL have gnt  output  NUM_REQ  one-hot, one-cycle grant pulse.
REQ-009 SHALL have coord_valid, coord_data  input  1, COORD_W  shared coordinate stream.
REQ-010 SHALL have coord_ready  output  1  coordinate accept.
REQ-011 SHALL have pt_valid  output  1; pt_data  output  MAX_DIM*COORD_W (coordinate k in slice k); pt_dim  output  2; pt_owner  output  2; completed-point result.
REQ-012 SHALL have pt_ready  input  1  result accept.
REQ-013 SHALL have err_dim  output  1  one-cycle pulse on illegal dimension.

Function
REQ-014 SHALL implement FSM states IDLE, FILL, OUT.
REQ-015 IDLE: if any req high, SHALL pulse gnt for the round-robin winner that cycle, latch its index and dim, clear pt_data.
REQ-016 Round-robin: search starts at index ptr, ptr = last granted index + 1 modulo NUM_REQ, updated on every grant.
REQ-017 Granted dim in 1..MAX_DIM: next state FILL, beat counter = 0.
REQ-018 Granted dim 0 or > MAX_DIM: SHALL pulse err_dim same cycle as gnt, stay IDLE, no fill, no pt_valid.
REQ-019 FILL: coord_ready = 1; beat accepted when coord_valid && coord_ready; beat k written to pt_data slice k.
REQ-020 Accept of beat dim-1: next state OUT; no further coord_ready.
REQ-021 coord_valid low in FILL: SHALL wait indefinitely, counter unchanged.
REQ-022 Slices >= dim SHALL read zero.
REQ-023 OUT: pt_valid = 1, pt_data/pt_dim/pt_owner stable until pt_ready; on pt_valid && pt_ready -> IDLE next cycle.
REQ-024 Earliest new grant SHALL be the cycle after OUT handshake; no grant in FILL or OUT.
REQ-025 Latency: grant cycle T, beats at T+1..T+dim if stream always valid, pt_valid at T+dim+1.
REQ-026 coord_ready SHALL be 0 in IDLE and OUT; beats offered then are not consumed.
REQ-027 Requests dropped before grant are ignored; req_dim sampled only in grant cycle.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, ptr = 0, counter = 0, pt_data = 0, and gnt, coord_ready, pt_valid, err_dim, pt_dim, pt_owner = 0.
REQ-029 Reset mid-FILL or mid-OUT SHALL discard the partial/pending point; first grant after release follows ptr = 0.

Verification
REQ-030 req=001, dim0=1, stream 3 -> gnt=001, pt_valid 2 cycles after grant, pt_data={0,0,3}, pt_dim=1, pt_owner=0.
REQ-031 req=111, dims 1,2,3, stream 3,4,5,6,7,8 -> grants 0,1,2 in order; points {3}, {4,5}, {6,7,8}.
REQ-032 req0 held continuously with req1 -> grants alternate 0,1,0,1; no starvation.
REQ-033 req=010, dim1=0 -> gnt=010 and err_dim pulse same cycle, no pt_valid, next grant goes to requester 2 before 1.
REQ-034 dim=3, coord_valid gaps and pt_ready held low 5 cycles -> pt_data stable {6,7,8}, coord_ready 0 during OUT, no extra beats consumed.
REQ-035 rst_n low after 2 of 3 beats -> all outputs 0 immediately; after release, fresh fill with 3,4,5 yields {3,4,5} with no stale data.
